// File: rtl/pdecoder_16_accum_if.sv
// Index-stream input and reconstructed-mask output bundle for pdecoder_16_accum.
// Handshake: a transfer happens on a rising clock edge where valid && ready are
// both high; the source holds its payload stable while valid && !ready.
interface pdecoder_16_accum_if #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] in_idx;
   logic             in_zero;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_mask;
   logic [IDX_W:0]   out_count;
   logic             out_dup;

   // Producer of index beats and consumer of results.
   modport master (
      output in_valid, in_idx, in_zero, in_last, out_ready,
      input  in_ready, out_valid, out_mask, out_count, out_dup
   );

   // The reconstructor itself.
   modport slave (
      input  in_valid, in_idx, in_zero, in_last, out_ready,
      output in_ready, out_valid, out_mask, out_count, out_dup
   );
endinterface

// File: rtl/pdecoder_16_accum.sv
// Rebuilds a 16-bit mask from the index list produced by the leading-one
// encoder. Index 0 names the MSB. Each group ends with an in_last beat, and its
// mask, popcount and duplicate flag are then held in a registered output slot.
module pdecoder_16_accum #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   pdecoder_16_accum_if.slave     bus
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [IDX_W:0]   cnt_q, cnt_d;
   logic             dup_q, dup_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_mask_q, out_mask_d;
   logic [IDX_W:0]   out_count_q, out_count_d;
   logic             out_dup_q, out_dup_d;

   logic             accept;
   logic             hit;
   logic [WIDTH-1:0] bit_oh;
   logic [WIDTH-1:0] acc_upd;
   logic [IDX_W:0]   cnt_upd;
   logic             dup_upd;

   // The output slot can take a new result when empty or being drained this cycle.
   assign bus.in_ready  = reset_n && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;

   assign bus.out_valid = out_valid_q;
   assign bus.out_mask  = out_mask_q;
   assign bus.out_count = out_count_q;
   assign bus.out_dup   = out_dup_q;

   // Working values after folding in the current beat (zero-marker beats add nothing).
   always_comb begin
      bit_oh = '0;
      bit_oh[IDX_W'(WIDTH-1) - bus.in_idx] = 1'b1;
      hit     = |(acc_q & bit_oh);
      acc_upd = acc_q;
      cnt_upd = cnt_q;
      dup_upd = dup_q;
      if (!bus.in_zero) begin
         acc_upd = acc_q | bit_oh;
         if (hit) begin
            dup_upd = 1'b1;
         end else begin
            cnt_upd = cnt_q + {{IDX_W{1'b0}}, 1'b1};
         end
      end
   end

   // Next state: accumulate, close a group into the output slot, drain the slot.
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      dup_d       = dup_q;
      out_valid_d = out_valid_q;
      out_mask_d  = out_mask_q;
      out_count_d = out_count_q;
      out_dup_d   = out_dup_q;
      if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (accept) begin
         if (bus.in_last) begin
            // A last beat can land in the same edge that drains the old result.
            out_valid_d = 1'b1;
            out_mask_d  = acc_upd;
            out_count_d = cnt_upd;
            out_dup_d   = dup_upd;
            acc_d       = '0;
            cnt_d       = '0;
            dup_d       = 1'b0;
         end else begin
            acc_d = acc_upd;
            cnt_d = cnt_upd;
            dup_d = dup_upd;
         end
      end
   end

   // State registers; reset discards any partial group and pending result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         dup_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_mask_q  <= '0;
         out_count_q <= '0;
         out_dup_q   <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         dup_q       <= dup_d;
         out_valid_q <= out_valid_d;
         out_mask_q  <= out_mask_d;
         out_count_q <= out_count_d;
         out_dup_q   <= out_dup_d;
      end
   end

endmodule

// File: doc/pdecoder_16_accum.md
# pdecoder_16_accum

Bitmask reconstructor that is the inverse of the 16-to-4 leading-one priority encoder. It accepts a stream of 4-bit essential-bit indices for one group, which is what repeated encode-and-clear of a mask produces, and ORs them into a 16-bit accumulator. It emits the rebuilt mask, the population count and a duplicate flag through a registered valid/ready output. It sits on the decompression side of the bit-serial datapath and restores the masks that the encoder side compressed into index lists.

## Interface
- WIDTH, 16, mask width. Only 16 is supported.
- IDX_W, 4, index width, equal to log2(WIDTH).

- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  index beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_idx  in  IDX_W  index using the encoder's convention: 0 selects mask bit 15 (MSB), 15 selects bit 0.
- in_zero  in  1  empty-group marker (the encoder's is_zero); the beat contributes no bit and in_idx is ignored.
- in_last  in  1  final beat of the group.
- out_valid  out  1  result held in the output register.
- out_ready  in  1  consumer accepts the result.
- out_mask  out  WIDTH  reconstructed mask.
- out_count  out  IDX_W+1  number of distinct bits set (0..16).
- out_dup  out  1  at least one index in the group hit an already-set bit.

## Operation
- Per-group working state: acc[15:0], cnt[4:0], dup. All three clear to 0 at reset and after every accepted last beat.
- Accepted beat with in_zero=0: set bit b = 15 - in_idx. If acc[b] was already 1, set dup and leave cnt unchanged. Otherwise increment cnt.
- Accepted beat with in_zero=1: acc and cnt are unchanged. This is legal on any beat; the encoder only sends it as a single beat with in_last=1.
- Accepted beat with in_last=1: load out_mask/out_count/out_dup from the updated values, including the current beat's contribution. Set out_valid=1 and clear acc/cnt/dup in the same edge.
- in_ready = !out_valid || out_ready. This is a combinational path from out_ready. in_ready is 0 while reset_n=0.
- Output handshake: out_valid drops on the edge where out_valid && out_ready, unless a new last beat is accepted on that same edge. In that case the output register reloads and out_valid stays 1.
- While out_valid && !out_ready: out_mask/out_count/out_dup are stable and no beats are accepted, including non-last beats.
- The cnt width guarantees no overflow. Sixteen distinct indices give count 16. Any further beats must duplicate, so cnt saturates naturally.
- Reset (async, reset_n low) in the middle of a group discards the partial group. Reset values: out_valid=0, out_mask=0, out_count=0, out_dup=0, acc=0, cnt=0, dup=0.

## Timing
- Latency: out_valid rises on the first rising edge after the accepted last beat, i.e. visible in the following cycle.
- Throughput: one beat per cycle. Single-beat groups produce one result per cycle when out_ready is held at 1.
- Back-to-back: a group can start accumulating in the cycle after its predecessor's last beat, while that result is still pending, provided the consumer accepts it at that point (in_ready follows out_ready).
- reset_n assertion takes effect immediately. Deassertion is synchronized by the system; the block is ready on the first edge after release.

## Test plan
- Beats idx 0, 3, 15 (last on 15), out_ready=1 -> next cycle out_valid=1, out_mask=16'h9001, out_count=3, out_dup=0.
- Single beat in_zero=1, in_last=1 -> out_mask=16'h0000, out_count=0, out_dup=0.
- Beats idx 5, 5 (last) -> out_mask=16'h0400, out_count=1, out_dup=1.
- Group A (idx 1, last), then out_ready=0 for 3 cycles -> in_ready=0 and out_mask=16'h4000 stable for 3 cycles. Group B's beat (idx 14, last) is presented throughout. On release, A is consumed and B is accepted in the same cycle, and the next cycle shows out_mask=16'h0002 with out_valid still 1.
- Beat idx 2 accepted, reset_n pulsed low mid-group, then beat idx 7 with last -> out_mask=16'h0100, out_count=1. During reset, all outputs are 0 and in_ready=0.
- All 16 indices 15..0 in descending order, last on 0 -> out_mask=16'hFFFF, out_count=16, out_dup=0. A following stream of single-beat groups with out_ready=1 yields one out_valid result every cycle.
